// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell encodings, line table and types for the tic-tac-toe judge
package ttt_pkg;

    typedef logic [1:0] cell_t;
    typedef logic [2:0] line_idx_t;
    typedef logic [3:0] cell_idx_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_X     = 2'b01;
    localparam cell_t CELL_O     = 2'b10;
    localparam cell_t CELL_RSVD  = 2'b11;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;
    localparam int BOARD_W   = 2 * NUM_CELLS;

    // Rows, then columns, then the two diagonals; scan order defines winLine.
    localparam cell_idx_t LINE_TABLE [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic cell_occupied(input cell_t c);
        return (c == CELL_X) || (c == CELL_O);
    endfunction

endpackage

// File: rtl/ttt_judge_if.sv
// rtl/ttt_judge_if.sv - judge request/result bundle; score ports exist only with JUDGE_SCORE_EN
interface ttt_judge_if
`ifdef JUDGE_SCORE_EN
    #(parameter int SCORE_W = 8)
`endif
;
    logic        start;
    logic [17:0] gBoard;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic [2:0]  winLine;
    logic        draw;
`ifdef JUDGE_SCORE_EN
    logic [SCORE_W-1:0] xWins;
    logic [SCORE_W-1:0] oWins;
    logic [SCORE_W-1:0] draws;

    modport master (output start, gBoard,
                    input  busy, done, winner, winLine, draw, xWins, oWins, draws);
    modport slave  (input  start, gBoard,
                    output busy, done, winner, winLine, draw, xWins, oWins, draws);
`else
    modport master (output start, gBoard,
                    input  busy, done, winner, winLine, draw);
    modport slave  (input  start, gBoard,
                    output busy, done, winner, winLine, draw);
`endif

endinterface

// File: rtl/ttt_line_mux.sv
// rtl/ttt_line_mux.sv - selects the three cells of one line from the snapshot and flags a win
module ttt_line_mux
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] i_snapshot,
    input  line_idx_t          i_line_idx,
    output cell_t              o_cell_a,
    output cell_t              o_cell_b,
    output cell_t              o_cell_c,
    output logic               o_line_win,
    output cell_t              o_line_val
);

    logic [4:0] w_bit_a;
    logic [4:0] w_bit_b;
    logic [4:0] w_bit_c;

    assign w_bit_a = {LINE_TABLE[i_line_idx][0], 1'b0};
    assign w_bit_b = {LINE_TABLE[i_line_idx][1], 1'b0};
    assign w_bit_c = {LINE_TABLE[i_line_idx][2], 1'b0};

    assign o_cell_a = i_snapshot[w_bit_a +: 2];
    assign o_cell_b = i_snapshot[w_bit_b +: 2];
    assign o_cell_c = i_snapshot[w_bit_c +: 2];

    // Empty and reserved cells can never form a win even when all three match.
    assign o_line_win = (o_cell_a == o_cell_b) && (o_cell_b == o_cell_c) && cell_occupied(o_cell_a);
    assign o_line_val = o_line_win ? o_cell_a : CELL_EMPTY;

endmodule

// File: rtl/ttt_judge.sv
// rtl/ttt_judge.sv - one-line-per-clock win/draw judge; JUDGE_SCORE_EN adds saturating score counters
module ttt_judge
    import ttt_pkg::*;
#(
    parameter int SCORE_W = 8
)(
    input  logic        clk,
    input  logic        reset,
    ttt_judge_if.slave  bus
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             r_state;
    logic [BOARD_W-1:0] r_snap;
    line_idx_t          r_line;
    logic               r_full;
    logic               r_busy;
    logic               r_done;
    cell_t              r_winner;
    line_idx_t          r_win_line;
    logic               r_draw;

    cell_t w_cell_a;
    cell_t w_cell_b;
    cell_t w_cell_c;
    logic  w_line_win;
    cell_t w_line_val;
    logic  w_cells_occ;
    logic  w_last_line;

    if (SCORE_W < 1) begin : g_score_w_check
        $error("SCORE_W must be at least 1");
    end

    ttt_line_mux u_line_mux (
        .i_snapshot (r_snap),
        .i_line_idx (r_line),
        .o_cell_a   (w_cell_a),
        .o_cell_b   (w_cell_b),
        .o_cell_c   (w_cell_c),
        .o_line_win (w_line_win),
        .o_line_val (w_line_val)
    );

    // Rows 0..2 cover every cell, so occupancy folded over the scan equals a full-board test.
    assign w_cells_occ = cell_occupied(w_cell_a) && cell_occupied(w_cell_b) && cell_occupied(w_cell_c);
    assign w_last_line = (r_line == line_idx_t'(NUM_LINES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_snap     <= '0;
            r_line     <= '0;
            r_full     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_winner   <= CELL_EMPTY;
            r_win_line <= '0;
            r_draw     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_snap     <= bus.gBoard;
                        r_line     <= '0;
                        r_full     <= 1'b1;
                        r_busy     <= 1'b1;
                        r_winner   <= CELL_EMPTY;
                        r_win_line <= '0;
                        r_draw     <= 1'b0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_line_win) begin
                        r_winner   <= w_line_val;
                        r_win_line <= r_line;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else if (w_last_line) begin
                        r_draw     <= r_full && w_cells_occ;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_line     <= r_line + 1'b1;
                        r_full     <= r_full && w_cells_occ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.winner  = r_winner;
    assign bus.winLine = r_win_line;
    assign bus.draw    = r_draw;

`ifdef JUDGE_SCORE_EN
    logic [SCORE_W-1:0] r_x_wins;
    logic [SCORE_W-1:0] r_o_wins;
    logic [SCORE_W-1:0] r_draws;
    logic               w_fin_x;
    logic               w_fin_o;
    logic               w_fin_draw;

    assign w_fin_x    = (r_state == SCAN) && w_line_win && (w_line_val == CELL_X);
    assign w_fin_o    = (r_state == SCAN) && w_line_win && (w_line_val == CELL_O);
    assign w_fin_draw = (r_state == SCAN) && !w_line_win && w_last_line && r_full && w_cells_occ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_wins <= '0;
            r_o_wins <= '0;
            r_draws  <= '0;
        end else begin
            if (w_fin_x && (r_x_wins != '1))
                r_x_wins <= r_x_wins + 1'b1;
            if (w_fin_o && (r_o_wins != '1))
                r_o_wins <= r_o_wins + 1'b1;
            if (w_fin_draw && (r_draws != '1))
                r_draws <= r_draws + 1'b1;
        end
    end

    assign bus.xWins = r_x_wins;
    assign bus.oWins = r_o_wins;
    assign bus.draws = r_draws;
`endif

endmodule

// File: tb/tb_ttt_judge.sv
// tb/tb_ttt_judge.sv - randomized and directed checks of ttt_judge against a behavioural model
module tb_ttt_judge;

`ifdef JUDGE_SCORE_EN
    localparam int SW = 2;
`else
    localparam int SW = 8;
`endif

    typedef struct packed {
        logic [1:0] w;
        logic [2:0] line;
        logic       draw;
        logic [3:0] lat;
    } res_t;

    localparam int LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    logic clk;
    logic reset;
    int   tests;
    int   fails;

`ifdef JUDGE_SCORE_EN
    ttt_judge_if #(.SCORE_W(SW)) u_if ();
`else
    ttt_judge_if u_if ();
`endif

    ttt_judge #(.SCORE_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Judgement straight from the rules: first winning line in table order, else full-board draw.
    function automatic res_t judge(input logic [17:0] b);
        res_t r;
        int   cells [9];
        bit   full;
        r = '0;
        r.lat = 4'd8;
        for (int i = 0; i < 9; i++) cells[i] = int'(b[2*i +: 2]);
        for (int l = 0; l < 8; l++) begin
            int a, m, c;
            a = cells[LINES[l][0]];
            m = cells[LINES[l][1]];
            c = cells[LINES[l][2]];
            if (a == m && m == c && (a == 1 || a == 2)) begin
                r.w    = 2'(a);
                r.line = 3'(l);
                r.lat  = 4'(l + 1);
                return r;
            end
        end
        full = 1'b1;
        for (int i = 0; i < 9; i++) if (cells[i] == 0 || cells[i] == 3) full = 1'b0;
        r.draw = full;
        return r;
    endfunction

    logic         m_busy, m_done, m_draw;
    logic [1:0]   m_win;
    logic [2:0]   m_line;
    int           m_left;
    res_t         m_res;
    logic [SW-1:0] m_xw, m_ow, m_dr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_draw <= 1'b0;
            m_win  <= 2'b00; m_line <= 3'd0; m_left <= 0; m_res <= '0;
            m_xw   <= '0; m_ow <= '0; m_dr <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (u_if.start) begin
                    m_busy <= 1'b1;
                    m_win  <= 2'b00; m_line <= 3'd0; m_draw <= 1'b0;
                    m_res  <= judge(u_if.gBoard);
                    m_left <= int'(judge(u_if.gBoard).lat);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_win  <= m_res.w;
                    m_line <= m_res.line;
                    m_draw <= m_res.draw;
                    if (m_res.w == 2'b01 && m_xw != '1) m_xw <= m_xw + 1'b1;
                    if (m_res.w == 2'b10 && m_ow != '1) m_ow <= m_ow + 1'b1;
                    if (m_res.draw && m_dr != '1) m_dr <= m_dr + 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy",    32'(u_if.busy),    32'(m_busy));
        check("done",    32'(u_if.done),    32'(m_done));
        check("winner",  32'(u_if.winner),  32'(m_win));
        check("winLine", 32'(u_if.winLine), 32'(m_line));
        check("draw",    32'(u_if.draw),    32'(m_draw));
`ifdef JUDGE_SCORE_EN
        check("xWins", 32'(u_if.xWins), 32'(m_xw));
        check("oWins", 32'(u_if.oWins), 32'(m_ow));
        check("draws", 32'(u_if.draws), 32'(m_dr));
`endif
    end

    task automatic wait_done(input string nm, input int lat0, input int exp_lat,
                             input logic [1:0] ew, input logic [2:0] el, input logic ed);
        int lat;
        bit got;
        lat = lat0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (u_if.done) got = 1'b1;
        end
        check({nm, "_latency"}, got ? 32'(lat) : 32'hDEAD, 32'(exp_lat));
        check({nm, "_winner"},  32'(u_if.winner),  32'(ew));
        check({nm, "_winLine"}, 32'(u_if.winLine), 32'(el));
        check({nm, "_draw"},    32'(u_if.draw),    32'(ed));
    endtask

    task automatic do_judge(input string nm, input logic [17:0] b, input int exp_lat,
                            input logic [1:0] ew, input logic [2:0] el, input logic ed);
        @(posedge clk); #2;
        u_if.start  = 1'b1;
        u_if.gBoard = b;
        @(posedge clk); #2;
        u_if.start = 1'b0;
        wait_done(nm, 0, exp_lat, ew, el, ed);
    endtask

    function automatic logic [17:0] rand_board(input bit full_only);
        logic [17:0] b;
        int v;
        for (int i = 0; i < 9; i++) begin
            v = full_only ? $urandom_range(2, 9) : $urandom_range(0, 9);
            b[2*i +: 2] = (v == 0) ? 2'b00 : (v == 1) ? 2'b11 : ((v % 2) != 0) ? 2'b01 : 2'b10;
        end
        return b;
    endfunction

    initial begin
        int dones;
        logic [SW-1:0] d0;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        u_if.start  = 1'b0;
        u_if.gBoard = '0;
        #1;
        check("reset_outputs", {27'd0, u_if.busy, u_if.done, u_if.winner, u_if.draw},
              32'd0);
        check("reset_winLine", 32'(u_if.winLine), 32'd0);

        check("model_row",  32'(judge(18'h00015)), 32'({2'b01, 3'd0, 1'b0, 4'd1}));
        check("model_col",  32'(judge(18'h08208)), 32'({2'b10, 3'd4, 1'b0, 4'd5}));
        check("model_draw", 32'(judge(18'h16A59)), 32'({2'b00, 3'd0, 1'b1, 4'd8}));
        check("model_rsvd", 32'(judge(18'h0003F)), 32'({2'b00, 3'd0, 1'b0, 4'd8}));

        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Reset three edges into a scan of an empty board.
        @(posedge clk); #2;
        u_if.start  = 1'b1;
        u_if.gBoard = 18'h00000;
        @(posedge clk); #2;
        u_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midscan_reset", {27'd0, u_if.busy, u_if.done, u_if.winner, u_if.draw}, 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        do_judge("after_reset", 18'h00000, 8, 2'b00, 3'd0, 1'b0);

        do_judge("row_win", 18'h00015, 1, 2'b01, 3'd0, 1'b0);
        do_judge("col_win", 18'h08208, 5, 2'b10, 3'd4, 1'b0);
`ifdef JUDGE_SCORE_EN
        d0 = u_if.draws;
`else
        d0 = '0;
`endif
        do_judge("draw", 18'h16A59, 8, 2'b00, 3'd0, 1'b1);
`ifdef JUDGE_SCORE_EN
        check("draws_incr", 32'(u_if.draws), 32'(d0) + 32'd1);
`endif

        // Reserved row, board changed at E2, stray start at E3.
        @(posedge clk); #2;
        u_if.start  = 1'b1;
        u_if.gBoard = 18'h0003F;
        @(posedge clk); #2;
        u_if.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        u_if.gBoard = 18'h00015;
        u_if.start  = 1'b1;
        @(posedge clk); #2;
        u_if.start = 1'b0;
        wait_done("reserved", 3, 8, 2'b00, 3'd0, 1'b0);

        @(posedge clk); #2;
        u_if.start  = 1'b1;
        u_if.gBoard = 18'h00015;
        dones = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (u_if.done) dones++;
        end
        u_if.start = 1'b0;
        check("back_to_back_dones", 32'(dones), 32'd5);
`ifdef JUDGE_SCORE_EN
        check("xWins_saturate", 32'(u_if.xWins), 32'd3);
`endif
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #2;
            u_if.start  = ($urandom % 4) != 0;
            u_if.gBoard = rand_board(($urandom % 3) == 0);
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        u_if.start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
